// File: rtl/median_rank_filter.sv
// Streaming rank-order filter: insertion-sorts one window of samples as they
// arrive and emits the median, min or max together with the window centre
// address as a one-cycle write strobe.
module median_rank_filter #(
    parameter int DATA_W   = 8,
    parameter int WIN_SIZE = 9,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dataValid,
    input  logic [ADDR_W-1:0] xAddressIn,
    input  logic [ADDR_W-1:0] yAddressIn,
    input  logic [DATA_W-1:0] dataIn,
    input  logic [1:0]        mode,
    output logic              writeEnable,
    output logic [ADDR_W-1:0] xMedianAddress,
    output logic [ADDR_W-1:0] yMedianAddress,
    output logic [DATA_W-1:0] dataOut,
    output logic              windowAbort
);

    localparam int CNT_W = $clog2(WIN_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIN_SIZE - 1);
    localparam logic [CNT_W-1:0] CNT_CENTRE = CNT_W'(WIN_SIZE / 2);

    logic [CNT_W-1:0]  cnt;
    logic [1:0]        modeReg;
    logic [ADDR_W-1:0] xCentre;
    logic [ADDR_W-1:0] yCentre;
    logic [DATA_W-1:0] sortArr [WIN_SIZE];
    logic [DATA_W-1:0] nextArr [WIN_SIZE];
    logic [WIN_SIZE-1:0] keep;
    logic [DATA_W-1:0] rankVal;

    // keep[i]: entry i is valid and <= the new sample, so it stays in place.
    // Because the valid entries are sorted, keep is a contiguous prefix and
    // its length is the insert position; ties stay ahead of the new sample.
    for (genvar i = 0; i < WIN_SIZE; i++) begin : g_insert
        assign keep[i] = (CNT_W'(i) < cnt) && (sortArr[i] <= dataIn);
        if (i == 0) begin : g_first
            assign nextArr[0] = keep[0] ? sortArr[0] : dataIn;
        end else begin : g_rest
            assign nextArr[i] = keep[i]   ? sortArr[i] :
                                keep[i-1] ? dataIn     : sortArr[i-1];
        end
    end

    // Pick the requested rank out of the array as it will look after this sample.
    always_comb begin
        rankVal = nextArr[WIN_SIZE/2];
        case (modeReg)
            2'd1:    rankVal = nextArr[0];
            2'd2:    rankVal = nextArr[WIN_SIZE-1];
            default: rankVal = nextArr[WIN_SIZE/2];
        endcase
    end

    // Sample counting, sorting, mode/centre capture, result and abort strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt            <= '0;
            modeReg        <= '0;
            xCentre        <= '0;
            yCentre        <= '0;
            writeEnable    <= 1'b0;
            windowAbort    <= 1'b0;
            dataOut        <= '0;
            xMedianAddress <= '0;
            yMedianAddress <= '0;
            for (int i = 0; i < WIN_SIZE; i++) begin
                sortArr[i] <= '0;
            end
        end else begin
            writeEnable <= 1'b0;
            windowAbort <= 1'b0;
            if (dataValid) begin
                for (int i = 0; i < WIN_SIZE; i++) begin
                    sortArr[i] <= nextArr[i];
                end
                if (cnt == '0) begin
                    modeReg <= mode;
                end
                if (cnt == CNT_CENTRE) begin
                    xCentre <= xAddressIn;
                    yCentre <= yAddressIn;
                end
                if (cnt == CNT_LAST) begin
                    cnt            <= '0;
                    dataOut        <= rankVal;
                    xMedianAddress <= xCentre;
                    yMedianAddress <= yCentre;
                    writeEnable    <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (cnt != '0) begin
                cnt         <= '0;
                windowAbort <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_median_rank_filter.sv
// Directed bench for median_rank_filter: 8-bit 3x3 instance checked through a
// result scoreboard, plus a 1-bit instance checked for majority behaviour.
module tb_median_rank_filter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       dataValid = 1'b0;
    logic [7:0] xAddressIn = '0;
    logic [7:0] yAddressIn = '0;
    logic [7:0] dataIn = '0;
    logic [1:0] mode = '0;
    logic       writeEnable;
    logic [7:0] xMedianAddress;
    logic [7:0] yMedianAddress;
    logic [7:0] dataOut;
    logic       windowAbort;

    logic       dv1 = 1'b0;
    logic [0:0] d1 = '0;
    logic       we1;
    logic [7:0] xm1;
    logic [7:0] ym1;
    logic [0:0] dout1;
    logic       abort1;

    median_rank_filter #(.DATA_W(8), .WIN_SIZE(9), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .dataValid(dataValid),
        .xAddressIn(xAddressIn), .yAddressIn(yAddressIn), .dataIn(dataIn), .mode(mode),
        .writeEnable(writeEnable), .xMedianAddress(xMedianAddress),
        .yMedianAddress(yMedianAddress), .dataOut(dataOut), .windowAbort(windowAbort)
    );

    median_rank_filter #(.DATA_W(1), .WIN_SIZE(9), .ADDR_W(8)) dutBit (
        .clk(clk), .reset(reset), .dataValid(dv1),
        .xAddressIn(8'd0), .yAddressIn(8'd0), .dataIn(d1), .mode(2'd0),
        .writeEnable(we1), .xMedianAddress(xm1),
        .yMedianAddress(ym1), .dataOut(dout1), .windowAbort(abort1)
    );

    typedef struct {
        int d;
        int x;
        int y;
    } exp_t;

    exp_t sb[$];
    int   totalChecks = 0;
    int   passedChecks = 0;
    int   cyc = 0;
    int   strobeLast = 0;
    int   strobePrev = 0;
    int   abortCount = 0;
    int   lastExp = 0;
    int   wv[9];
    int   wb[9];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        totalChecks++;
        assert (obs === exp) passedChecks++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Output monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (windowAbort === 1'b1) abortCount++;
        if (writeEnable === 1'b1) begin
            strobePrev = strobeLast;
            strobeLast = cyc;
            check("strobe_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("dataOut", int'(dataOut), e.d);
                check("xMedianAddress", int'(xMedianAddress), e.x);
                check("yMedianAddress", int'(yMedianAddress), e.y);
            end
        end
    end

    function automatic int modelRank(input int v[9], input int m);
        int s[9];
        int t;
        s = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j]; s[j] = s[j+1]; s[j+1] = t;
                end
        case (m)
            1:       return s[0];
            2:       return s[8];
            default: return s[4];
        endcase
    endfunction

    task automatic sendSample(input int d, input int x, input int y, input int m);
        dataValid  = 1'b1;
        dataIn     = 8'(d);
        xAddressIn = 8'(x);
        yAddressIn = 8'(y);
        mode       = 2'(m);
        @(posedge clk);
        #1;
    endtask

    // Sends one full window; mode switches to mAfter from sample index switchAt.
    task automatic runWindow(input int v[9], input int mFirst, input int switchAt,
                             input int mAfter, input int cx, input int cy);
        exp_t e;
        e.d = modelRank(v, mFirst);
        e.x = cx;
        e.y = cy;
        lastExp = e.d;
        sb.push_back(e);
        for (int i = 0; i < 9; i++) begin
            sendSample(v[i], (i == 4) ? cx : 100 + i, (i == 4) ? cy : 200 + i,
                       (i >= switchAt) ? mAfter : mFirst);
        end
        check("writeEnable_latency", int'(writeEnable), 1);
    endtask

    task automatic idle(input int n);
        dataValid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle(2);
        check("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic runBitWindow(input int v[9], input string tag);
        int ones = 0;
        for (int i = 0; i < 9; i++) begin
            ones += v[i];
            dv1 = 1'b1;
            d1  = 1'(v[i]);
            @(posedge clk);
            #1;
        end
        dv1 = 1'b0;
        check({tag, "_we"}, int'(we1), 1);
        check({tag, "_data"}, int'(dout1), (ones > 4) ? 1 : 0);
        @(posedge clk);
        #1;
        check({tag, "_we_drop"}, int'(we1), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_we", int'(writeEnable), 0);
        check("reset_abort", int'(windowAbort), 0);
        check("reset_data", int'(dataOut), 0);
        check("reset_x", int'(xMedianAddress), 0);
        check("reset_y", int'(yMedianAddress), 0);
        reset = 1'b0;
        idle(2);

        wv = '{10, 200, 30, 40, 50, 60, 70, 80, 90};
        runWindow(wv, 0, 9, 0, 5, 7);
        drain();
        check("hold_data", int'(dataOut), lastExp);
        check("hold_we", int'(writeEnable), 0);
        runWindow(wv, 1, 9, 1, 11, 12);
        drain();
        runWindow(wv, 2, 9, 2, 13, 14);
        drain();
        runWindow(wv, 0, 2, 2, 15, 16);
        drain();
        runWindow(wv, 3, 9, 3, 17, 18);
        drain();

        wv = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
        runWindow(wv, 0, 9, 0, 21, 22);
        wv = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
        runWindow(wv, 0, 9, 0, 23, 24);
        drain();
        check("b2b_spacing", strobeLast - strobePrev, 9);

        a0 = abortCount;
        for (int i = 0; i < 5; i++) sendSample(i + 1, i, i, 0);
        dataValid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_pulse", int'(windowAbort), 1);
        check("abort_no_we", int'(writeEnable), 0);
        @(posedge clk);
        #1;
        check("abort_single", int'(windowAbort), 0);
        idle(3);
        check("abort_count", abortCount - a0, 1);
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        runWindow(wv, 0, 9, 0, 31, 32);
        drain();

        a0 = abortCount;
        for (int i = 0; i < 6; i++) sendSample(50 + i, i, i, 0);
        reset = 1'b1;
        dataValid = 1'b0;
        #1;
        check("midreset_data", int'(dataOut), 0);
        check("midreset_x", int'(xMedianAddress), 0);
        check("midreset_y", int'(yMedianAddress), 0);
        check("midreset_we", int'(writeEnable), 0);
        check("midreset_abort", int'(windowAbort), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);
        wv = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
        runWindow(wv, 0, 9, 0, 41, 42);
        drain();
        check("midreset_no_abort", abortCount - a0, 0);

        wb = '{1, 0, 1, 1, 0, 0, 1, 0, 0};
        runBitWindow(wb, "maj0");
        wb = '{1, 1, 0, 1, 0, 1, 1, 0, 0};
        runBitWindow(wb, "maj1");

        check("final_scoreboard", sb.size(), 0);
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
